// File: rtl/forward_result_pipe.sv
// forward_result_pipe: three-slot history of results leaving EXE.
// Slot 1 is the youngest (PC-4), slot 3 the oldest (PC-12).
// It publishes each slot's destination register and answers the forwarding
// unit's 2-bit select codes with data. Loads enter not-ready and are filled
// later by the memory return strobe, oldest pending slot first.
module forward_result_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              advance,
    input  logic              flush,
    input  logic              exe_valid,
    input  logic [REG_W-1:0]  exe_write_reg,
    input  logic [DATA_W-1:0] exe_result,
    input  logic              exe_is_load,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        sel_a,
    input  logic [1:0]        sel_b,
    input  logic [1:0]        sel_br_a,
    input  logic [1:0]        sel_br_b,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b,
    output logic [DATA_W-1:0] fwd_br_a,
    output logic [DATA_W-1:0] fwd_br_b,
    output logic              data_pending,
    output logic [REG_W-1:0]  slot_reg_1,
    output logic [REG_W-1:0]  slot_reg_2,
    output logic [REG_W-1:0]  slot_reg_3,
    output logic              fill_err
);

    // Registered slot state; index 1 = youngest
    logic [3:1]        r_vld;
    logic [3:1]        r_rdy;
    logic [REG_W-1:0]  r_reg  [1:3];
    logic [DATA_W-1:0] r_data [1:3];
    logic              r_fill_err;

    // Fill target (one-hot over slots) and post-fill, pre-shift slot view
    logic [3:1]        w_tgt;
    logic              w_no_tgt;
    logic [3:1]        w_frdy;
    logic [DATA_W-1:0] w_fdata [1:3];

    // Normalised new entry from EXE; an invalid entry is stored as reg 0,
    // data 0, ready so that invalid slots never need output-side special cases
    logic              w_new_vld;
    logic [REG_W-1:0]  w_new_reg;
    logic [DATA_W-1:0] w_new_data;
    logic              w_new_rdy;

    // Read-side lookup tables indexed directly by a select code (0 = none)
    logic [DATA_W-1:0] w_rd_data [0:3];
    logic [3:0]        w_pend;

    // New entry formed from the EXE-stage inputs
    always_comb begin
        w_new_vld  = exe_valid & (exe_write_reg != '0);
        w_new_reg  = w_new_vld ? exe_write_reg : '0;
        w_new_data = (w_new_vld & ~exe_is_load) ? exe_result : '0;
        w_new_rdy  = ~w_new_vld | ~exe_is_load;
    end

    // Oldest pending load slot receives returning memory data
    always_comb begin
        w_tgt = 3'b000;
        if (mem_rdata_valid) begin
            if (r_vld[3] & ~r_rdy[3])
                w_tgt = 3'b100;
            else if (r_vld[2] & ~r_rdy[2])
                w_tgt = 3'b010;
            else if (r_vld[1] & ~r_rdy[1])
                w_tgt = 3'b001;
        end
        w_no_tgt = mem_rdata_valid & (w_tgt == 3'b000);
    end

    // Apply the fill to the pre-shift slot contents
    always_comb begin
        w_frdy = r_rdy | w_tgt;
        for (int n = 1; n <= 3; n++)
            w_fdata[n] = w_tgt[n] ? mem_rdata : r_data[n];
    end

    // Slot history update: fill, optional shift, then slot-1 flush
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vld      <= '0;
            r_rdy      <= '1;
            r_fill_err <= 1'b0;
            for (int n = 1; n <= 3; n++) begin
                r_reg[n]  <= '0;
                r_data[n] <= '0;
            end
        end else begin
            if (advance) begin
                r_vld[3]  <= r_vld[2];
                r_rdy[3]  <= w_frdy[2];
                r_reg[3]  <= r_reg[2];
                r_data[3] <= w_fdata[2];
                r_vld[2]  <= r_vld[1];
                r_rdy[2]  <= w_frdy[1];
                r_reg[2]  <= r_reg[1];
                r_data[2] <= w_fdata[1];
                r_vld[1]  <= w_new_vld;
                r_rdy[1]  <= w_new_rdy;
                r_reg[1]  <= w_new_reg;
                r_data[1] <= w_new_data;
            end else begin
                r_rdy <= w_frdy;
                for (int n = 1; n <= 3; n++)
                    r_data[n] <= w_fdata[n];
            end
            // Flush wins over whatever slot 1 would otherwise hold
            if (flush) begin
                r_vld[1]  <= 1'b0;
                r_rdy[1]  <= 1'b1;
                r_reg[1]  <= '0;
                r_data[1] <= '0;
            end
            if (w_no_tgt)
                r_fill_err <= 1'b1;
        end
    end

    // Per-select read values: data only from valid, ready slots
    always_comb begin
        w_rd_data[0] = '0;
        w_pend[0]    = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            w_rd_data[n] = (r_vld[n] & r_rdy[n]) ? r_data[n] : '0;
            w_pend[n]    = r_vld[n] & ~r_rdy[n];
        end
    end

    assign fwd_a        = w_rd_data[sel_a];
    assign fwd_b        = w_rd_data[sel_b];
    assign fwd_br_a     = w_rd_data[sel_br_a];
    assign fwd_br_b     = w_rd_data[sel_br_b];
    assign data_pending = w_pend[sel_a] | w_pend[sel_b] | w_pend[sel_br_a] | w_pend[sel_br_b];
    assign slot_reg_1   = r_vld[1] ? r_reg[1] : '0;
    assign slot_reg_2   = r_vld[2] ? r_reg[2] : '0;
    assign slot_reg_3   = r_vld[3] ? r_reg[3] : '0;
    assign fill_err     = r_fill_err;

endmodule

// File: tb/tb_forward_result_pipe.sv
// Bench for forward_result_pipe: directed vector table, two hand-written
// corner sequences, then randomized traffic against a slot-list model.
module tb_forward_result_pipe;

    logic        CLK = 1'b0;
    logic        RESET, advance, flush, exe_valid, exe_is_load, mem_rdata_valid;
    logic [4:0]  exe_write_reg;
    logic [31:0] exe_result, mem_rdata;
    logic [1:0]  sel_a, sel_b, sel_br_a, sel_br_b;
    logic [31:0] fwd_a, fwd_b, fwd_br_a, fwd_br_b;
    logic        data_pending, fill_err;
    logic [4:0]  slot_reg_1, slot_reg_2, slot_reg_3;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    forward_result_pipe #(.DATA_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .advance(advance), .flush(flush),
        .exe_valid(exe_valid), .exe_write_reg(exe_write_reg),
        .exe_result(exe_result), .exe_is_load(exe_is_load),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .sel_a(sel_a), .sel_b(sel_b), .sel_br_a(sel_br_a), .sel_br_b(sel_br_b),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_br_a(fwd_br_a), .fwd_br_b(fwd_br_b),
        .data_pending(data_pending), .slot_reg_1(slot_reg_1),
        .slot_reg_2(slot_reg_2), .slot_reg_3(slot_reg_3), .fill_err(fill_err)
    );

    typedef struct {
        bit rst, adv, fl, ev;
        bit [4:0] rg;
        bit [31:0] res;
        bit ld, mrv;
        bit [31:0] mrd;
        bit [1:0] sa, sb, sbra, sbrb;
        bit [4:0] e1, e2, e3;
        bit [31:0] ea, eb, ebra, ebrb;
        bit ep, ef;
    } row_t;

    // Reference model: list of three history entries, youngest first
    typedef struct {
        bit vld;
        bit [4:0] rg;
        bit [31:0] d;
        bit rdy;
    } ent_t;
    ent_t m[1:3];
    bit   m_ferr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit adv, input bit fl, input bit ev,
                         input bit [4:0] rg, input bit [31:0] res, input bit ld,
                         input bit mrv, input bit [31:0] mrd, input bit [1:0] sa,
                         input bit [1:0] sb, input bit [1:0] sbra, input bit [1:0] sbrb);
        @(negedge CLK);
        RESET = rst; advance = adv; flush = fl; exe_valid = ev;
        exe_write_reg = rg; exe_result = res; exe_is_load = ld;
        mem_rdata_valid = mrv; mem_rdata = mrd;
        sel_a = sa; sel_b = sb; sel_br_a = sbra; sel_br_b = sbrb;
        @(posedge CLK);
        #1;
    endtask

    function automatic bit [31:0] m_fwd(input bit [1:0] s);
        if (s == 0) return 0;
        return (m[s].vld && m[s].rdy) ? m[s].d : 32'h0;
    endfunction

    function automatic bit m_pend(input bit [1:0] s);
        if (s == 0) return 0;
        return m[s].vld && !m[s].rdy;
    endfunction

    // Advance the model by one clock edge using the current inputs
    task automatic model_step();
        ent_t nw;
        bit found;
        if (RESET) begin
            for (int k = 1; k <= 3; k++) m[k] = '{0, 0, 0, 1};
            m_ferr = 0;
            return;
        end
        found = 0;
        if (mem_rdata_valid) begin
            for (int k = 3; k >= 1; k--) begin
                if (!found && m[k].vld && !m[k].rdy) begin
                    m[k].d = mem_rdata;
                    m[k].rdy = 1;
                    found = 1;
                end
            end
            if (!found) m_ferr = 1;
        end
        if (advance) begin
            nw.vld = exe_valid && (exe_write_reg != 0);
            nw.rg  = exe_write_reg;
            nw.rdy = !exe_is_load;
            nw.d   = exe_is_load ? 32'h0 : exe_result;
            m[3] = m[2];
            m[2] = m[1];
            m[1] = nw;
        end
        if (flush) m[1].vld = 0;
    endtask

    row_t tbl[19];

    initial begin
        RESET = 1; advance = 0; flush = 0; exe_valid = 0; exe_write_reg = 0;
        exe_result = 0; exe_is_load = 0; mem_rdata_valid = 0; mem_rdata = 0;
        sel_a = 0; sel_b = 0; sel_br_a = 0; sel_br_b = 0;

        //          rst adv fl ev rg  res         ld mrv mrd           sa sb bra brb e1 e2 e3  ea            eb            ebra          ebrb     ep ef
        tbl[0]  = '{1, 0, 0, 0, 0,  0,          0, 0, 0,            1, 1, 1, 1,  0, 0, 0,  0,            0,            0,            0,       0, 0};
        tbl[1]  = '{0, 1, 0, 1, 8,  'h11,       0, 0, 0,            1, 0, 0, 0,  8, 0, 0,  'h11,         0,            0,            0,       0, 0};
        tbl[2]  = '{0, 1, 0, 1, 9,  'h22,       0, 0, 0,            1, 2, 0, 0,  9, 8, 0,  'h22,         'h11,         0,            0,       0, 0};
        tbl[3]  = '{0, 1, 0, 1, 10, 'h33,       0, 0, 0,            1, 3, 2, 0,  10, 9, 8, 'h33,         'h11,         'h22,         0,       0, 0};
        tbl[4]  = '{0, 0, 0, 1, 20, 'hAA,       0, 0, 0,            1, 3, 2, 0,  10, 9, 8, 'h33,         'h11,         'h22,         0,       0, 0};
        tbl[5]  = '{0, 0, 0, 1, 21, 'hAB,       1, 0, 0,            1, 3, 2, 0,  10, 9, 8, 'h33,         'h11,         'h22,         0,       0, 0};
        tbl[6]  = '{0, 0, 0, 1, 22, 'hAC,       0, 0, 0,            1, 3, 2, 0,  10, 9, 8, 'h33,         'h11,         'h22,         0,       0, 0};
        tbl[7]  = '{0, 0, 0, 1, 23, 'hAD,       1, 0, 0,            1, 3, 2, 0,  10, 9, 8, 'h33,         'h11,         'h22,         0,       0, 0};
        tbl[8]  = '{0, 1, 0, 1, 5,  'h99,       1, 0, 0,            1, 2, 3, 0,  5, 10, 9, 0,            'h33,         'h22,         0,       1, 0};
        tbl[9]  = '{0, 0, 0, 1, 17, 'h1,        0, 1, 'hDEADBEEF,   1, 2, 3, 0,  5, 10, 9, 'hDEADBEEF,   'h33,         'h22,         0,       0, 0};
        tbl[10] = '{0, 1, 0, 1, 5,  'h98,       1, 0, 0,            1, 2, 3, 0,  5, 5, 10, 0,            'hDEADBEEF,   'h33,         0,       1, 0};
        tbl[11] = '{0, 1, 0, 1, 7,  'h77,       0, 1, 'h1234,       2, 1, 3, 2,  7, 5, 5,  'h1234,       'h77,         'hDEADBEEF,   'h1234,  0, 0};
        tbl[12] = '{0, 1, 1, 1, 12, 'hC,        0, 0, 0,            1, 2, 3, 0,  0, 7, 5,  0,            'h77,         'h1234,       0,       0, 0};
        tbl[13] = '{0, 1, 0, 1, 0,  'h55,       0, 0, 0,            1, 3, 2, 0,  0, 0, 7,  0,            'h77,         0,            0,       0, 0};
        tbl[14] = '{0, 0, 0, 0, 0,  0,          0, 1, 'hFACE,       0, 3, 0, 0,  0, 0, 7,  0,            'h77,         0,            0,       0, 1};
        tbl[15] = '{0, 1, 0, 1, 3,  'h3,        0, 0, 0,            1, 0, 0, 0,  3, 0, 0,  'h3,          0,            0,            0,       0, 1};
        tbl[16] = '{0, 1, 0, 1, 4,  'h4,        0, 0, 0,            1, 2, 0, 0,  4, 3, 0,  'h4,          'h3,          0,            0,       0, 1};
        tbl[17] = '{0, 1, 0, 1, 6,  'h6,        0, 0, 0,            1, 2, 3, 1,  6, 4, 3,  'h6,          'h4,          'h3,          'h6,     0, 1};
        tbl[18] = '{1, 1, 0, 1, 11, 'hB,        0, 1, 'h5,          1, 2, 3, 1,  0, 0, 0,  0,            0,            0,            0,       0, 0};

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].adv, tbl[i].fl, tbl[i].ev, tbl[i].rg, tbl[i].res,
                  tbl[i].ld, tbl[i].mrv, tbl[i].mrd, tbl[i].sa, tbl[i].sb, tbl[i].sbra, tbl[i].sbrb);
            chk($sformatf("row%0d slot_reg_1", i), 32'(slot_reg_1), 32'(tbl[i].e1));
            chk($sformatf("row%0d slot_reg_2", i), 32'(slot_reg_2), 32'(tbl[i].e2));
            chk($sformatf("row%0d slot_reg_3", i), 32'(slot_reg_3), 32'(tbl[i].e3));
            chk($sformatf("row%0d fwd_a", i), fwd_a, tbl[i].ea);
            chk($sformatf("row%0d fwd_b", i), fwd_b, tbl[i].eb);
            chk($sformatf("row%0d fwd_br_a", i), fwd_br_a, tbl[i].ebra);
            chk($sformatf("row%0d fwd_br_b", i), fwd_br_b, tbl[i].ebrb);
            chk($sformatf("row%0d data_pending", i), 32'(data_pending), 32'(tbl[i].ep));
            chk($sformatf("row%0d fill_err", i), 32'(fill_err), 32'(tbl[i].ef));
        end

        // Fill aimed at slot 1 while slot 1 is flushed without advancing
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 9, 'h90, 1, 0, 0, 1, 0, 0, 0);
        chk("seqA load pending", 32'(data_pending), 32'd1);
        drive(0, 0, 1, 1, 14, 'h91, 0, 1, 'h4242, 1, 0, 0, 0);
        chk("seqA slot_reg_1", 32'(slot_reg_1), 32'd0);
        chk("seqA fwd_a", fwd_a, 32'd0);
        chk("seqA fill_err", 32'(fill_err), 32'd0);

        // Fill aimed at slot 3 is discarded by a simultaneous advance
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1, 'h10, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 2, 'h20, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 3, 'h30, 0, 0, 0, 0, 0, 0, 3);
        chk("seqB slot3 pending", 32'(data_pending), 32'd1);
        chk("seqB slot_reg_3", 32'(slot_reg_3), 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 'hABC, 3, 2, 1, 0);
        chk("seqB fill_err after drop", 32'(fill_err), 32'd0);
        chk("seqB slot_reg_3 shifted", 32'(slot_reg_3), 32'd2);
        chk("seqB fwd_a", fwd_a, 32'h20);
        chk("seqB fwd_b", fwd_b, 32'h30);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 'hABD, 0, 0, 0, 0);
        chk("seqB fill_err orphan", 32'(fill_err), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = (i == 0) || ($urandom_range(0, 63) == 0);
            @(negedge CLK);
            RESET = rst;
            advance = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            exe_valid = ($urandom_range(0, 5) != 0);
            exe_write_reg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            exe_result = $urandom;
            exe_is_load = ($urandom_range(0, 2) == 0);
            mem_rdata_valid = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            sel_a = 2'($urandom); sel_b = 2'($urandom);
            sel_br_a = 2'($urandom); sel_br_b = 2'($urandom);
            model_step();
            @(posedge CLK);
            #1;
            chk("rnd slot_reg_1", 32'(slot_reg_1), 32'(m[1].vld ? m[1].rg : 5'd0));
            chk("rnd slot_reg_2", 32'(slot_reg_2), 32'(m[2].vld ? m[2].rg : 5'd0));
            chk("rnd slot_reg_3", 32'(slot_reg_3), 32'(m[3].vld ? m[3].rg : 5'd0));
            chk("rnd fwd_a", fwd_a, m_fwd(sel_a));
            chk("rnd fwd_b", fwd_b, m_fwd(sel_b));
            chk("rnd fwd_br_a", fwd_br_a, m_fwd(sel_br_a));
            chk("rnd fwd_br_b", fwd_br_b, m_fwd(sel_br_b));
            chk("rnd data_pending", 32'(data_pending),
                32'(m_pend(sel_a) | m_pend(sel_b) | m_pend(sel_br_a) | m_pend(sel_br_b)));
            chk("rnd fill_err", 32'(fill_err), 32'(m_ferr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forward_result_pipe.md
Name: forward_result_pipe

Overview:
- Data-side counterpart of the forwarding unit. The forwarding unit consumes destination-register history and issues 2-bit select codes; this block produces that history and answers those selects with data.
- Keeps a 3-slot history of retired-from-EXE results: slot 1 = PC-4, slot 2 = PC-8, slot 3 = PC-12.
- Exports each slot's destination register and valid bit.
- Returns forwarded data for the EXE A/B and branch/JR A/B select codes. Flags when a selected result is an outstanding load.

Parameters:
- DATA_W, 32, result/data width
- REG_W, 5, register index width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- advance  in  1  pipeline moves this cycle; low = hold all slots
- flush  in  1  squash the entry in slot 1
- exe_valid  in  1  EXE instruction writes a register
- exe_write_reg  in  REG_W  EXE destination register
- exe_result  in  DATA_W  EXE result (ignored for loads)
- exe_is_load  in  1  EXE instruction is a load; data arrives later
- mem_rdata_valid  in  1  load data return strobe
- mem_rdata  in  DATA_W  load data
- sel_a, sel_b, sel_br_a, sel_br_b  in  2 each  select codes: 0 none, 1/2/3 = slot 1/2/3
- fwd_a, fwd_b, fwd_br_a, fwd_br_b  out  DATA_W each  forwarded data
- data_pending  out  1  some nonzero select addresses a valid, not-ready slot
- slot_reg_1, slot_reg_2, slot_reg_3  out  REG_W each  slot destination; 0 when slot invalid
- fill_err  out  1  sticky: load data returned with no pending slot

Behaviour:
- Slot state per slot n: vld, reg, data, rdy. All of it is registered.
- Reset (RESET high at a CLK edge): all vld, reg, data = 0, rdy = 1, fill_err = 0. Reset overrides every other input.
- Entry capture: new_vld = exe_valid & (exe_write_reg != 0); new_rdy = !exe_is_load; new_data = exe_is_load ? 0 : exe_result.
- advance = 1: slot 3 <= slot 2, slot 2 <= slot 1, slot 1 <= new entry. The slot 3 entry is dropped.
- advance = 0: all slots hold; EXE inputs are ignored.
- flush = 1: slot 1 post-update vld = 0. This applies with or without advance. Slots 2 and 3 are untouched.
- Load fill, when mem_rdata_valid = 1:
  - Target is the oldest pre-update slot with vld & !rdy, searched slot 3, then 2, then 1.
  - That slot gets data <= mem_rdata, rdy <= 1.
  - If advance is also 1, the fill lands in the slot's post-shift position. A target in slot 3 is discarded along with the shift.
  - If flush is also 1, a slot-1 target stays invalidated.
  - No pending slot: data is dropped and fill_err <= 1, held until reset.
- Invalid slots always read rdy = 1 and data = 0.
- Outputs are combinational from registered state, so an entry captured at edge k is visible after edge k (one-cycle latency):
  - fwd_x = slot[sel_x].data when sel_x != 0 and that slot is vld & rdy; otherwise 0.
  - data_pending = OR over the four selects of (sel != 0 & slot vld & !rdy).
  - slot_reg_n = vld ? reg : 0.
- A duplicate destination across slots is legal. Priority is resolved by the requester's select code, not by this block.

Test Plan:
- Reset, then 3 advances with exe_valid=1, regs 8/9/10, results 0x11/0x22/0x33 → slot_reg_1/2/3 = 10/9/8; sel_a=1 gives 0x33, sel_b=3 gives 0x11, sel_br_a=2 gives 0x22.
- advance=0 for 4 cycles with changing EXE inputs → slot regs and fwd values unchanged.
- Load to reg 5, advance, then sel_a=1 → data_pending=1, fwd_a=0. Next cycle mem_rdata_valid=1 with 0xDEADBEEF, advance=0 → fwd_a=0xDEADBEEF, data_pending=0.
- Load to reg 5 with advance, then mem_rdata_valid=1 and advance=1 in the same cycle with data 0x1234 → the reg-5 entry moves to slot 2 with data 0x1234, rdy=1.
- flush=1 with advance=1 → slot_reg_1=0; sel_a=1 gives 0; slots 2/3 hold the prior slot 1/2 contents. Then exe_write_reg=0 with exe_valid=1 → slot_reg_1=0, invalid.
- mem_rdata_valid=1 with no pending load → fill_err=1 and stays 1; RESET mid-stream with slots full → all slot_reg=0 and fill_err=0 the next cycle.
